a2d_conv_sched: RTL and testbench

Round-robin conversion scheduler that owns the SPI master driving the DE0 A2D, an ADC128S-style part. It runs one conversion slot per timer tick, cycling through four channels: battery, current, brake and torque. Each slot is two SPI transactions: the first sends the channel, the second returns the 12-bit result. Results are held in registers with per-channel update strobes that feed sensor conditioning, the brake_n compare and the TX telemetry.

---
 rtl/a2d_conv_sched.sv | 219 +++++++++++++++++++++
 tb/tb_a2d_conv_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_conv_sched.sv
// a2d_conv_sched: round-robin conversion scheduler for the DE0 A2D (ADC128S-style).
// One slot per timer tick, cycling battery -> current -> brake -> torque. Each slot sends
// the channel in a first SPI transaction and reads the 12-bit result in a second one.
// FAST_SIM=1 shortens the tick period to 2^9 clks for simulation.
// Optional feature: define A2D_OVERSAMPLE_EN to run 4 conversions per slot and store
// the 14-bit sum shifted right by two.
module a2d_conv_sched #(
  parameter bit          FAST_SIM  = 1'b1,
  parameter int unsigned PERIOD_W  = 14,
  parameter logic [2:0]  CH_BATT   = 3'd0,
  parameter logic [2:0]  CH_CURR   = 3'd1,
  parameter logic [2:0]  CH_BRAKE  = 3'd3,
  parameter logic [2:0]  CH_TORQUE = 3'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic [3:0]  rdy,
  output logic        ovr
);

  localparam int unsigned CntW = FAST_SIM ? 32'd9 : PERIOD_W;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCmd  = 3'd1;
  localparam logic [2:0] StGap  = 3'd2;
  localparam logic [2:0] StRead = 3'd3;
`ifdef A2D_OVERSAMPLE_EN
  localparam logic [2:0] StNext = 3'd4;
`endif

  logic [CntW-1:0] cnt_q;
  logic            tick;
  logic            pending_q;
  logic            ovr_q;
  logic [2:0]      state_q, state_d;
  logic            launch;
  logic            wrt_d, wrt_q;
  logic            store;
  logic            rd_done;
  logic            last_conv;
  logic [1:0]      slot_q;
  logic [2:0]      chnl;
  logic [15:0]     cmd_q;
  logic [11:0]     result;
  logic [11:0]     batt_q, curr_q, brake_q, torque_q;
  logic [3:0]      rdy_q;
  logic            unused_rd;

  // Tick fires on the all-ones count; a held counter (en low) never ticks.
  assign tick    = en & (&cnt_q);
  assign launch  = (state_q == StIdle) & en & (pending_q | tick);
  assign rd_done = (state_q == StRead) & spi_done;

  // Upper read bits carry no conversion data on this part.
  assign unused_rd = ^spi_rd[15:12];

  // Free-running tick counter, frozen while scheduling is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Single-entry tick queue; a tick that finds it full is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (tick && pending_q) begin
        ovr_q <= 1'b1;
      end
      if (launch) begin
        pending_q <= 1'b0;
      end else if (tick) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Channel number for the slot currently being served.
  always_comb begin
    chnl = CH_BATT;
    unique case (slot_q)
      2'd0: chnl = CH_BATT;
      2'd1: chnl = CH_CURR;
      2'd2: chnl = CH_BRAKE;
      2'd3: chnl = CH_TORQUE;
      default: chnl = CH_BATT;
    endcase
  end

`ifdef A2D_OVERSAMPLE_EN
  logic [1:0]  conv_q;
  logic [13:0] sum_q;
  logic [13:0] sum_nxt;

  assign sum_nxt   = sum_q + {2'b00, spi_rd[11:0]};
  assign last_conv = (conv_q == 2'd3);
  assign result    = sum_nxt[13:2];

  // Accumulate the four samples of a slot; the sum restarts once the slot is stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_q <= '0;
      sum_q  <= '0;
    end else if (rd_done) begin
      conv_q <= conv_q + 2'd1;
      sum_q  <= last_conv ? '0 : sum_nxt;
    end
  end
`else
  assign last_conv = 1'b1;
  assign result    = spi_rd[11:0];
`endif

  // Slot sequencer: command transaction, one dead clk, result transaction.
  always_comb begin
    state_d = state_q;
    wrt_d   = 1'b0;
    store   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          wrt_d   = 1'b1;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (spi_done) begin
          state_d = StGap;
        end
      end
      StGap: begin
        wrt_d   = 1'b1;
        state_d = StRead;
      end
      StRead: begin
        if (spi_done) begin
          store = last_conv;
`ifdef A2D_OVERSAMPLE_EN
          state_d = last_conv ? StIdle : StNext;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef A2D_OVERSAMPLE_EN
      // Dead clk before the next conversion of the same channel.
      StNext: begin
        wrt_d   = 1'b1;
        state_d = StCmd;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state, SPI start strobe and the command word held for the whole slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wrt_q   <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      wrt_q   <= wrt_d;
      if (launch) begin
        cmd_q <= {2'b00, chnl, 11'h000};
      end
    end
  end

  // Result registers, update strobes and slot pointer move together on the final read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_q   <= '0;
      curr_q   <= '0;
      brake_q  <= '0;
      torque_q <= '0;
      rdy_q    <= '0;
      slot_q   <= '0;
    end else begin
      rdy_q <= '0;
      if (store) begin
        rdy_q  <= 4'b0001 << slot_q;
        slot_q <= slot_q + 2'd1;
        unique case (slot_q)
          2'd0: batt_q   <= result;
          2'd1: curr_q   <= result;
          2'd2: brake_q  <= result;
          2'd3: torque_q <= result;
          default: batt_q <= result;
        endcase
      end
    end
  end

  assign spi_wrt = wrt_q;
  assign spi_cmd = cmd_q;
  assign batt    = batt_q;
  assign curr    = curr_q;
  assign brake   = brake_q;
  assign torque  = torque_q;
  assign rdy     = rdy_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Testbench for a2d_conv_sched: SPI slave model plus a transaction-level reference that
// derives every output from tick counts, transaction counts and the data returned.
module tb_a2d_conv_sched;

  localparam int Period = 512;
`ifdef A2D_OVERSAMPLE_EN
  localparam int G = 8;  // SPI transactions per slot
`else
  localparam int G = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd = '0;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic [11:0] batt, curr, brake, torque;
  logic [3:0]  rdy;
  logic        ovr;

  a2d_conv_sched #(.FAST_SIM(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .spi_done (spi_done),
    .spi_rd   (spi_rd),
    .spi_wrt  (spi_wrt),
    .spi_cmd  (spi_cmd),
    .batt     (batt),
    .curr     (curr),
    .brake    (brake),
    .torque   (torque),
    .rdy      (rdy),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  int          en_cnt, n_wrt, n_done, slot, edge_idx;
  bit          owed, exp_ovr;
  logic [13:0] acc;
  logic [11:0] res [4];
  logic [2:0]  ch_tab [4] = '{3'd0, 3'd1, 3'd3, 3'd4};

  // SPI slave model
  bit          s_busy, spurious;
  int          s_cd, dmin, dmax, long_n;
  logic [11:0] dq [$];

  // event log
  int          first_wrt_edge, first_rdy_edge, rdy_done_ref, last_done_drive;
  logic [15:0] first_wrt_cmd;
  logic [3:0]  first_rdy;
  logic [15:0] cmd_log [$];
  logic [3:0]  rdy_log [$];

  task automatic finish_bench();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_idx);
    end
  endtask

  task automatic model_reset();
    en_cnt = 0; n_wrt = 0; n_done = 0; slot = 0; edge_idx = -1;
    owed = 0; exp_ovr = 0; acc = '0;
    for (int i = 0; i < 4; i++) res[i] = '0;
    s_busy = 0; s_cd = 0; long_n = 0; last_done_drive = -10;
    first_wrt_edge = -1; first_rdy_edge = -1; rdy_done_ref = -10;
    first_wrt_cmd = 'x; first_rdy = 'x;
    cmd_log.delete(); rdy_log.delete();
  endtask

  // One clock: reference update for the edge just taken, compare, then SPI slave response.
  task automatic step();
    logic        en_s, done_s, tick, idle, ew;
    logic [15:0] rd_s;
    logic [3:0]  erdy;
    int          outst;
    en_s = en; done_s = spi_done; rd_s = spi_rd;
    @(negedge clk);
    edge_idx++;
    tick = 1'b0;
    if (en_s) begin
      en_cnt++;
      tick = (en_cnt % Period) == 0;
    end
    outst = n_wrt - n_done;
    idle  = (outst == 0) && (n_done % G == 0);
    ew    = 1'b0;
    erdy  = '0;
    if (tick && owed) exp_ovr = 1'b1;
    if (idle && en_s && (owed || tick)) begin
      ew   = 1'b1;
      owed = 1'b0;
    end else begin
      if (tick) owed = 1'b1;
      if (outst == 0 && !idle) ew = 1'b1;  // next transaction of a slot in progress
    end
    if (done_s && outst > 0) begin
      n_done++;
      if (n_done % 2 == 0) acc += {2'b00, rd_s[11:0]};
      if (n_done % G == 0) begin
        res[slot]  = (G == 2) ? acc[11:0] : acc[13:2];
        erdy[slot] = 1'b1;
        slot       = (slot + 1) % 4;
        acc        = '0;
      end
    end
    if (ew) n_wrt++;
    check("outputs", {spi_wrt, rdy, ovr, batt, curr, brake, torque},
          {ew, erdy, exp_ovr, res[0], res[1], res[2], res[3]});
    if (n_wrt != n_done || n_done % G != 0)
      check("spi_cmd", spi_cmd, {2'b00, ch_tab[slot], 11'h000});
    if (spi_wrt) begin
      cmd_log.push_back(spi_cmd);
      if (first_wrt_edge < 0) begin
        first_wrt_edge = edge_idx;
        first_wrt_cmd  = spi_cmd;
      end
    end
    if (rdy != 0) begin
      rdy_log.push_back(rdy);
      if (first_rdy_edge < 0) begin
        first_rdy_edge = edge_idx;
        first_rdy      = rdy;
        rdy_done_ref   = last_done_drive;
      end
    end
    // SPI slave
    if (spi_wrt) begin
      s_busy = 1'b1;
      if (long_n > 0) begin
        s_cd = 1100;
        long_n--;
      end else begin
        s_cd = $urandom_range(dmax, dmin);
      end
    end
    spi_done = 1'b0;
    spi_rd   = 16'($urandom);
    if (s_busy) begin
      if (s_cd == 0) begin
        spi_done = 1'b1;
        s_busy   = 1'b0;
        if (dq.size() > 0) spi_rd[11:0] = dq.pop_front();
        last_done_drive = edge_idx;
      end else begin
        s_cd--;
      end
    end else if (spurious && $urandom_range(15, 0) == 0) begin
      spi_done = 1'b1;
    end
    if (errors > 200) finish_bench();
  endtask

  // Asynchronous reset applied away from any clock edge; outputs must clear at once.
  task automatic do_reset(logic en_after);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    spi_done = 1'b0;
    #1;
    check("reset_ctl", {spi_wrt, spi_cmd, rdy, ovr}, '0);
    check("reset_res", {batt, curr, brake, torque}, '0);
    model_reset();
    repeat (3) @(negedge clk);
    en = en_after;
    rst_n = 1'b1;
  endtask

  task automatic wait_rdy(int nslots, int budget);
    int got = 0;
    while (got < nslots && budget > 0) begin
      step();
      if (rdy != 0) got++;
      budget--;
    end
    check("slots_done_in_time", got, nslots);
  endtask

  initial begin
    logic [15:0] exp_cmd [10] = '{16'h0000, 16'h0000, 16'h0800, 16'h0800, 16'h1800,
                                  16'h1800, 16'h2000, 16'h2000, 16'h0000, 16'h0000};
    int b;
    int n_before;
    spurious = 0; dmin = 1; dmax = 4;
    model_reset();

    // First slot after reset
`ifndef A2D_OVERSAMPLE_EN
    do_reset(1'b1);
    dq = '{12'hA5C, 12'hA5C};
    wait_rdy(1, 700);
    check("first_wrt_edge", first_wrt_edge, 511);
    check("first_wrt_cmd", first_wrt_cmd, 16'h0000);
    check("batt_a5c", batt, 12'hA5C);
    check("first_rdy", first_rdy, 4'b0001);
    check("rdy_lag", first_rdy_edge, rdy_done_ref + 1);

    // Four slots in round-robin order, then back to battery
    do_reset(1'b1);
    dq = '{12'h000, 12'h111, 12'h000, 12'h222, 12'h000, 12'h333, 12'h000, 12'h444};
    wait_rdy(5, 5 * Period + 300);
    for (int i = 0; i < 10; i++)
      check("cmd_seq", (i < cmd_log.size()) ? cmd_log[i] : 16'hxxxx, exp_cmd[i]);
    for (int i = 0; i < 5; i++)
      check("rdy_seq", (i < rdy_log.size()) ? rdy_log[i] : 4'hx, 4'b0001 << (i % 4));
    check("curr_val", curr, 12'h222);
    check("brake_val", brake, 12'h333);
    check("torque_val", torque, 12'h444);
`else
    do_reset(1'b1);
    dq = '{12'h000, 12'h100, 12'h000, 12'h101, 12'h000, 12'h102, 12'h000, 12'h103};
    wait_rdy(1, 700);
    check("os_batt", batt, 12'h101);
    check("os_wrt_count", cmd_log.size(), 8);
    check("os_first_cmd", first_wrt_cmd, 16'h0000);
    run_quiet: for (int i = 0; i < 100; i++) step();
    check("os_single_rdy", rdy_log.size(), 1);
    check("os_first_rdy", first_rdy, 4'b0001);
    wait_rdy(4, 5 * Period);
    check("os_rdy_last", rdy_log[rdy_log.size() - 1], 4'b0001);
`endif

    // SPI stalls longer than two tick periods: overrun flag, no skipped slot
    long_n = 1;
    wait_rdy(4, 8000);
    check("ovr_set", ovr, 1'b1);
    for (int i = 0; i < 700; i++) step();
    check("ovr_sticky", ovr, 1'b1);

    // en dropped while waiting for the brake result
    b = 6000;
    while (!(slot == 2 && n_done % G == G - 1 && n_wrt - n_done == 1) && b > 0) begin
      step();
      b--;
    end
    check("found_brake_read", b > 0, 1'b1);
    en = 1'b0;
    n_before = cmd_log.size();
    for (int i = 0; i < 1500; i++) step();
    check("brake_rdy", (rdy_log.size() > 0) ? rdy_log[rdy_log.size() - 1] : 4'hx, 4'b0100);
    check("no_wrt_while_off", cmd_log.size() - n_before, 0);
    en = 1'b1;
    wait_rdy(1, 1200);
    check("torque_after_en", rdy_log[rdy_log.size() - 1], 4'b1000);

    // Reset between the two transactions of a slot
    b = 2000;
    while (!(n_wrt - n_done == 1 && n_done % G == 0) && b > 0) begin
      step();
      b--;
    end
    check("found_mid_slot", b > 0, 1'b1);
    do_reset(1'b1);
    wait_rdy(1, 900);
    check("post_reset_wrt_edge", first_wrt_edge, 511);
    check("post_reset_rdy", first_rdy, 4'b0001);

    // Randomized: en toggling, variable SPI latency, spurious done pulses
    spurious = 1; dmin = 0; dmax = 30;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(199, 0) == 0) en = ~en;
      if ($urandom_range(1999, 0) == 0) long_n = 1;
      step();
    end
    finish_bench();
  end

endmodule
